// File: rtl/pre_analysis.sv
// Fetches the 128-bit key and one plaintext block from word memory and assembles them for the cipher core.
// Latency: done is asserted 9 cycles after start is accepted, or 5 cycles when a cached key is reused.
// Backpressure: none; a start that arrives while busy (including the done edge) is dropped.
// Optional feature: define PRE_ANALYSIS_KEY_CACHE_EN to keep the key between loads (key_reload forces a re-fetch).
module pre_analysis #(
    parameter logic [31:0] KEY_BASE = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         start,
    input  logic [11:0]  plain_address,
    input  logic         key_reload,
    input  logic [31:0]  mem_data_in,
    output logic [31:0]  address,
    output logic         read_enable,
    output logic [127:0] key_out,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_KEY   = 2'd1,
        S_DATA  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [11:0]  pa_q, pa_d;
    logic         done_q, done_d;

    // One-cycle-delayed copy of the read just issued: tells which slot mem_data_in belongs to.
    logic         cap_vld_q;
    logic         cap_key_q;
    logic [1:0]   cap_idx_q;

    logic [127:0] key_q;
    logic [127:0] data_q;

`ifdef PRE_ANALYSIS_KEY_CACHE_EN
    logic         key_valid_q, key_valid_d;
`else
    logic         unused_key_reload;
    assign unused_key_reload = key_reload;
`endif

    // Next-state, read strobe and address generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pa_d        = pa_q;
        done_d      = 1'b0;
        read_enable = 1'b0;
        address     = 32'h0000_0000;
`ifdef PRE_ANALYSIS_KEY_CACHE_EN
        key_valid_d = key_valid_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pa_d    = plain_address;
                    cnt_d   = 2'd0;
                    state_d = S_KEY;
`ifdef PRE_ANALYSIS_KEY_CACHE_EN
                    if (key_valid_q && !key_reload) begin
                        state_d = S_DATA;
                    end
`endif
                end
            end
            S_KEY: begin
                read_enable = 1'b1;
                address     = KEY_BASE + {30'b0, cnt_q};
                cnt_d       = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_DATA;
`ifdef PRE_ANALYSIS_KEY_CACHE_EN
                    key_valid_d = 1'b1;
`endif
                end
            end
            S_DATA: begin
                read_enable = 1'b1;
                address     = {20'b0, pa_q} + 32'd4 + {30'b0, cnt_q};
                cnt_d       = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                // Final data word lands this cycle; announce completion on the next one.
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            pa_q    <= 12'h000;
            done_q  <= 1'b0;
`ifdef PRE_ANALYSIS_KEY_CACHE_EN
            key_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pa_q    <= pa_d;
            done_q  <= done_d;
`ifdef PRE_ANALYSIS_KEY_CACHE_EN
            key_valid_q <= key_valid_d;
`endif
        end
    end

    // Track the outstanding read and write returning data into its key/data slot in place.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cap_vld_q <= 1'b0;
            cap_key_q <= 1'b0;
            cap_idx_q <= 2'd0;
            key_q     <= '0;
            data_q    <= '0;
        end else begin
            cap_vld_q <= read_enable;
            cap_key_q <= (state_q == S_KEY);
            cap_idx_q <= cnt_q;
            if (cap_vld_q) begin
                if (cap_key_q) begin
                    key_q[{cap_idx_q, 5'b0} +: 32] <= mem_data_in;
                end else begin
                    data_q[{cap_idx_q, 5'b0} +: 32] <= mem_data_in;
                end
            end
        end
    end

    assign key_out  = key_q;
    assign data_out = data_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

endmodule

// File: doc/pre_analysis.md
# pre_analysis

Memory-fetch stage ahead of the AES core: on `start` it reads the 128-bit key and one 128-bit plaintext block from word-addressed data memory as eight 32-bit reads. It assembles them into `key_out` and `data_out`, then pulses `done` to launch encryption. It is the mirror of the cipher write-back stage. Memory layout is shared with that stage: key at words KEY_BASE..KEY_BASE+3, plaintext block n at words `plain_address`+4..+7.

## Interface
- `KEY_BASE`, default 0: word address of key word 0.
- `CLK`  input  1  system clock; all state updates on rising edge.
- `RST_N`  input  1  reset; asynchronous and active-low.
- `start`  input  1  single-cycle load request; ignored while `busy`=1.
- `plain_address`  input  12  plaintext block offset; sampled on the edge that accepts `start`.
- `key_reload`  input  1  force key re-fetch on the next accepted `start`; used only with the macro below.
- `mem_data_in`  input  32  read data from memory, valid one cycle after the read is issued.
- `address`  output  32  memory word address; 0 whenever `read_enable`=0.
- `read_enable`  output  1  read strobe, one word per cycle.
- `key_out`  output  128  assembled key; word i occupies bits [32i+31:32i].
- `data_out`  output  128  assembled plaintext, same word ordering.
- `busy`  output  1  high from the accepting edge until `done`.
- `done`  output  1  one-cycle pulse; `key_out`/`data_out` valid and complete.

## Operation
- States: IDLE, KEY, DATA, DRAIN; 2-bit word counter `cnt`.
- IDLE:
  - `start`=1 -> latch `plain_address`, set `cnt`=0, go to KEY.
  - Under the macro with a valid cached key, go to DATA instead.
- KEY:
  - `read_enable`=1, `address`=KEY_BASE+`cnt`.
  - `cnt` wraps 3->0, then go to DATA.
- DATA:
  - `read_enable`=1, `address`={20'b0,`plain_address`}+4+`cnt`.
  - `cnt` wraps 3->0, then go to DRAIN.
- DRAIN: no read; capture the final word, pulse `done`, clear `busy`, go to IDLE.
- Capture:
  - Each read issued in cycle k lands in its slot from `mem_data_in` at the end of cycle k+1.
  - Slot = the key/data word index tracked by a one-cycle-delayed copy of (phase, `cnt`).
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32.
- `key_out`/`data_out` hold their values between loads.
  - Words are updated in place during a load.
  - Consumers sample only on `done`.
- `start` while `busy`=1 is dropped; there is no queueing.
- `start` on the same edge that `done` is asserted is dropped; `start` one cycle later is accepted.
- Reset (any time, including mid-load):
  - State returns to IDLE, `cnt`=0.
  - All outputs go to 0: `address`, `read_enable`, `key_out`, `data_out`, `busy`, `done`.
  - Key cache is invalidated.

## Timing
- Edge E0 accepts `start`.
- Key reads are issued in cycles E0..E0+3; data reads in cycles E0+4..E0+7.
- `done`=1 during the cycle after edge E0+9; `busy` is high from E0 through that edge.
- Load latency: 9 cycles with the key fetched, 5 cycles with a cached key.
- Memory read latency is exactly 1 cycle; no wait states are supported.

## Configuration
- `PRE_ANALYSIS_KEY_CACHE_EN` defined:
  - Internal `key_valid` flag, cleared by reset, set when a KEY phase completes.
  - An accepted `start` with `key_valid`=1 and `key_reload`=0 skips KEY.
  - `key_out` is held; 4 reads, 5-cycle latency.
  - `key_reload`=1 at start forces the KEY phase.
- Not defined:
  - Every load fetches the key (8 reads, 9-cycle latency).
  - `key_reload` is ignored and no `key_valid` flag exists.

## Test plan
- Reset then idle:
  - All outputs 0; `address`=0.
  - 20 cycles of no `start` -> no `read_enable`.
- Basic load, KEY_BASE=0, memory[i]=32'hA0000000+i, `plain_address`=12'h010:
  - Addresses 0,1,2,3,0x14,0x15,0x16,0x17 on consecutive cycles.
  - `done` at E0+9 (edge-relative as in Timing).
  - `key_out`={A0000003,A0000002,A0000001,A0000000}.
  - `data_out`={A0000017,A0000016,A0000015,A0000014}.
- Busy/back-to-back:
  - `start` re-pulsed at E0+3 -> ignored, exactly 8 reads.
  - `start` one cycle after `done` -> second load accepted.
  - `start` coincident with `done` -> dropped.
- Address wrap: KEY_BASE=32'hFFFFFFFE -> key addresses FFFFFFFE, FFFFFFFF, 0, 1.
- Reset asserted at E0+5 mid-DATA -> outputs 0 immediately; subsequent `start` performs a full 9-cycle load with correct values.
- With `PRE_ANALYSIS_KEY_CACHE_EN`:
  - First load 9 cycles.
  - Second load 5 cycles, data addresses only, `key_out` unchanged.
  - Third load with `key_reload`=1 -> 9 cycles, new key words captured.
